// File: rtl/alu_issue_sequencer_if.sv
// Instruction handshake plus the operand/result bus between the issue sequencer and the ALU.
// Operation and flag types are parameters so the instantiating scope supplies the ISA types.
interface alu_issue_sequencer_if #(
   parameter int  DataWidth      = 16,
   parameter int  ImmediateWidth = 8,
   parameter int  InstrWidth     = 16,
   parameter type opT            = logic [4:0],
   parameter type flagsT         = logic [3:0]
);

   logic                      InstrValid;
   logic                      InstrReady;
   logic [InstrWidth-1:0]     Instr;

   opT                        AluOperation;
   flagsT                     AluInFlags;
   logic [ImmediateWidth-1:0] AluInImm;
   logic [DataWidth-1:0]      AluInSrc;
   logic [DataWidth-1:0]      AluInDest;
   flagsT                     AluOutFlags;
   logic [DataWidth-1:0]      AluOutDest;

   modport master (
      input  InstrValid, Instr, AluOutFlags, AluOutDest,
      output InstrReady, AluOperation, AluInFlags, AluInImm, AluInSrc, AluInDest
   );

   modport slave (
      output InstrValid, Instr, AluOutFlags, AluOutDest,
      input  InstrReady, AluOperation, AluInFlags, AluInImm, AluInSrc, AluInDest
   );

endinterface

// File: rtl/alu_issue_sequencer.sv
// Four-state issue/writeback controller in front of the combinational ALU, with its own register file.
// Optional divide-by-zero trap enabled by defining DIV_ZERO_TRAP_EN.
package InstructionSetPkg;

   typedef enum logic [4:0] {
      OpNop  = 5'd0,
      OpMove = 5'd1,
      OpLil  = 5'd2,
      OpLih  = 5'd3,
      OpAdd  = 5'd4,
      OpAdc  = 5'd5,
      OpSub  = 5'd6,
      OpAnd  = 5'd7,
      OpOr   = 5'd8,
      OpXor  = 5'd9,
      OpDiv  = 5'd10,
      OpMod  = 5'd11
   } eOperation;

   typedef struct packed {
      logic Carry;
      logic Zero;
      logic Negative;
      logic Overflow;
   } sFlags;

endpackage

module alu_issue_sequencer
   import InstructionSetPkg::*;
#(
   parameter int DataWidth      = 16,
   parameter int ImmediateWidth = 8,
   parameter int NumRegs        = 8,
   parameter int InstrWidth     = 16
)(
   input  logic                         Clock,
   input  logic                         nReset,
   alu_issue_sequencer_if.master        aluBus,
   output logic                         Done,
   input  logic [$clog2(NumRegs)-1:0]   DbgAddr,
   output logic [DataWidth-1:0]         DbgData,
   output sFlags                        FlagsOut
`ifdef DIV_ZERO_TRAP_EN
   ,
   output logic                         DivZeroErr
`endif
);

   localparam int IdxWidth    = $clog2(NumRegs);
   localparam int OpcodeWidth = $bits(eOperation);
   localparam int OpcodeLsb   = InstrWidth - OpcodeWidth;
   localparam int DestLsb     = OpcodeLsb - IdxWidth;
   localparam int SrcLsb      = DestLsb - IdxWidth;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ      = 2'd1,
      EXECUTE   = 2'd2,
      WRITEBACK = 2'd3
   } seqState_t;

   seqState_t                 state;
   seqState_t                 nextState;

   logic [DataWidth-1:0]      regFile [NumRegs];
   sFlags                     flagReg;

   eOperation                 opReg;
   logic [IdxWidth-1:0]       destIdx;
   logic [IdxWidth-1:0]       srcIdx;
   logic [ImmediateWidth-1:0] immReg;

   logic [DataWidth-1:0]      srcOperand;
   logic [DataWidth-1:0]      destOperand;
   sFlags                     flagOperand;

   logic [DataWidth-1:0]      resultData;
   sFlags                     resultFlags;

   logic                      accept;
   logic                      latchOperands;
   logic                      captureResult;
   logic                      writeBack;

`ifdef DIV_ZERO_TRAP_EN
   logic                      trapHit;
   logic                      trapPending;
   logic                      divZeroErrReg;
`endif

   // State register; reset drops any in-flight instruction without a writeback
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and per-state strobes
   always_comb begin
      nextState         = state;
      aluBus.InstrReady = 1'b0;
      Done              = 1'b0;
      accept            = 1'b0;
      latchOperands     = 1'b0;
      captureResult     = 1'b0;
      writeBack         = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      trapHit           = 1'b0;
`endif
      case (state)
         IDLE: begin
            aluBus.InstrReady = 1'b1;
            if (aluBus.InstrValid) begin
               accept    = 1'b1;
               nextState = READ;
            end
         end
         READ: begin
            latchOperands = 1'b1;
            nextState     = EXECUTE;
`ifdef DIV_ZERO_TRAP_EN
            if (((opReg == OpDiv) || (opReg == OpMod)) && (regFile[srcIdx] == '0)) begin
               trapHit   = 1'b1;
               nextState = WRITEBACK;
            end
`endif
         end
         EXECUTE: begin
            captureResult = 1'b1;
            nextState     = WRITEBACK;
         end
         WRITEBACK: begin
            Done      = 1'b1;
`ifdef DIV_ZERO_TRAP_EN
            writeBack = !trapPending;
`else
            writeBack = 1'b1;
`endif
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Instruction fields are sampled only on an accepted handshake
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         opReg   <= eOperation'(0);
         destIdx <= '0;
         srcIdx  <= '0;
         immReg  <= '0;
      end else if (accept) begin
         opReg   <= eOperation'(aluBus.Instr[OpcodeLsb +: OpcodeWidth]);
         destIdx <= aluBus.Instr[DestLsb +: IdxWidth];
         srcIdx  <= aluBus.Instr[SrcLsb +: IdxWidth];
         immReg  <= aluBus.Instr[ImmediateWidth-1:0];
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         srcOperand  <= '0;
         destOperand <= '0;
         flagOperand <= '0;
      end else if (latchOperands) begin
         srcOperand  <= regFile[srcIdx];
         destOperand <= regFile[destIdx];
         flagOperand <= flagReg;
      end
   end

   // ALU outputs have settled through EXECUTE and are frozen here for writeback
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         resultData  <= '0;
         resultFlags <= '0;
      end else if (captureResult) begin
         resultData  <= aluBus.AluOutDest;
         resultFlags <= aluBus.AluOutFlags;
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         for (int i = 0; i < NumRegs; i++) begin
            regFile[i] <= '0;
         end
         flagReg <= '0;
      end else if (writeBack) begin
         regFile[destIdx] <= resultData;
         flagReg          <= resultFlags;
      end
   end

`ifdef DIV_ZERO_TRAP_EN
   // trapPending suppresses the current writeback; divZeroErrReg is sticky until reset
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         trapPending   <= 1'b0;
         divZeroErrReg <= 1'b0;
      end else begin
         if (accept) begin
            trapPending <= 1'b0;
         end else if (trapHit) begin
            trapPending <= 1'b1;
         end
         if (trapHit) begin
            divZeroErrReg <= 1'b1;
         end
      end
   end

   assign DivZeroErr = divZeroErrReg;
`endif

   assign aluBus.AluOperation = opReg;
   assign aluBus.AluInImm     = immReg;
   assign aluBus.AluInSrc     = srcOperand;
   assign aluBus.AluInDest    = destOperand;
   assign aluBus.AluInFlags   = flagOperand;

   assign DbgData  = regFile[DbgAddr];
   assign FlagsOut = flagReg;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer with a small behavioural ALU on the far side of the bus.
// Build with DIV_ZERO_TRAP_EN defined to exercise the divide-by-zero trap expectations.
module tb_alu_issue_sequencer;
   import InstructionSetPkg::*;

   logic        Clock = 1'b0;
   logic        nReset = 1'b0;
   logic        Done;
   logic [2:0]  DbgAddr = 3'd0;
   logic [15:0] DbgData;
   sFlags       FlagsOut;
`ifdef DIV_ZERO_TRAP_EN
   logic        DivZeroErr;
`endif

   int checks = 0;
   int errors = 0;

   alu_issue_sequencer_if #(.opT(eOperation), .flagsT(sFlags)) aluBus ();

   always #5 Clock = ~Clock;

   alu_issue_sequencer dut (
      .Clock    (Clock),
      .nReset   (nReset),
      .aluBus   (aluBus),
      .Done     (Done),
      .DbgAddr  (DbgAddr),
      .DbgData  (DbgData),
      .FlagsOut (FlagsOut)
`ifdef DIV_ZERO_TRAP_EN
      ,
      .DivZeroErr (DivZeroErr)
`endif
   );

   // Behavioural ALU: unknown opcodes give 0 and pass the flags through
   logic [16:0] sum;
   always_comb begin
      sum                = '0;
      aluBus.AluOutDest  = '0;
      aluBus.AluOutFlags = aluBus.AluInFlags;
      case (aluBus.AluOperation)
         OpMove: aluBus.AluOutDest = aluBus.AluInSrc;
         OpLil:  aluBus.AluOutDest = {8'h00, aluBus.AluInImm};
         OpLih:  aluBus.AluOutDest = {aluBus.AluInImm, aluBus.AluInDest[7:0]};
         OpAdd, OpAdc: begin
            sum = {1'b0, aluBus.AluInDest} + {1'b0, aluBus.AluInSrc}
                + ((aluBus.AluOperation == OpAdc) ? {16'd0, aluBus.AluInFlags.Carry} : 17'd0);
            aluBus.AluOutDest           = sum[15:0];
            aluBus.AluOutFlags.Carry    = sum[16];
            aluBus.AluOutFlags.Zero     = (sum[15:0] == 16'd0);
            aluBus.AluOutFlags.Negative = sum[15];
            aluBus.AluOutFlags.Overflow = (aluBus.AluInDest[15] == aluBus.AluInSrc[15])
                                        && (sum[15] != aluBus.AluInDest[15]);
         end
         OpDiv:  aluBus.AluOutDest = (aluBus.AluInSrc == 16'd0) ? 16'hFFFF
                                   : aluBus.AluInDest / aluBus.AluInSrc;
         OpMod:  aluBus.AluOutDest = (aluBus.AluInSrc == 16'd0) ? aluBus.AluInDest
                                   : aluBus.AluInDest % aluBus.AluInSrc;
         default: ;
      endcase
   end

   function automatic logic [15:0] mkInstr(input eOperation op, input logic [2:0] dest,
                                           input logic [7:0] low);
      return {op, dest, low};
   endfunction

   function automatic logic [7:0] srcField(input logic [2:0] src);
      return {src, 5'b00000};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkReg(input string tag, input logic [2:0] idx, input logic [15:0] expected);
      DbgAddr = idx;
      #1;
      checkOutput(tag, 32'(DbgData), 32'(expected));
   endtask

   // Issue one word, then check handshake, Done latency/width and return to IDLE
   task automatic applyStimulus(input logic [15:0] word, input int expLatency);
      int edges;
      @(negedge Clock);
      checkOutput("readyBeforeIssue", 32'(aluBus.InstrReady), 32'd1);
      aluBus.InstrValid = 1'b1;
      aluBus.Instr      = word;
      @(posedge Clock);
      #1;
      aluBus.InstrValid = 1'b0;
      aluBus.Instr      = '0;
      checkOutput("readyLowInRead", 32'(aluBus.InstrReady), 32'd0);
      edges = 0;
      while (!Done && edges < 8) begin
         @(posedge Clock);
         #1;
         edges++;
      end
      checkOutput("doneLatency", 32'(edges), 32'(expLatency));
      @(posedge Clock);
      #1;
      checkOutput("doneOneCycle", 32'(Done), 32'd0);
      checkOutput("readyAfterWriteback", 32'(aluBus.InstrReady), 32'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=timeout required=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [15:0] words [8];
      int          donePulses;
      int          doneSeen;
`ifdef DIV_ZERO_TRAP_EN
      int          divZeroLatency = 1;
      logic [15:0] r5AfterDivZero = 16'h0003;
`else
      int          divZeroLatency = 2;
      logic [15:0] r5AfterDivZero = 16'hFFFF;
`endif

      aluBus.InstrValid = 1'b0;
      aluBus.Instr      = '0;

      // Reset state
      repeat (2) @(posedge Clock);
      #1;
      checkOutput("resetReady", 32'(aluBus.InstrReady), 32'd1);
      checkOutput("resetDone", 32'(Done), 32'd0);
      checkOutput("resetFlags", 32'(FlagsOut), 32'd0);
      checkOutput("resetAluOp", 32'(aluBus.AluOperation), 32'd0);
      checkOutput("resetAluSrc", 32'(aluBus.AluInSrc), 32'd0);
      for (int i = 0; i < 8; i++) begin
         checkReg("resetReg", 3'(i), 16'h0000);
      end
      nReset = 1'b1;

      // Load immediate
      applyStimulus(mkInstr(OpLil, 3'd1, 8'h05), 2);
      checkReg("lilR1", 3'd1, 16'h0005);
      checkOutput("lilFlags", 32'(FlagsOut), 32'h0);

      // ADC carry-out and zero
      applyStimulus(mkInstr(OpLil, 3'd1, 8'hFF), 2);
      applyStimulus(mkInstr(OpLih, 3'd1, 8'hFF), 2);
      applyStimulus(mkInstr(OpLil, 3'd2, 8'h01), 2);
      checkReg("preloadR1", 3'd1, 16'hFFFF);
      checkReg("preloadR2", 3'd2, 16'h0001);
      applyStimulus(mkInstr(OpAdc, 3'd2, srcField(3'd1)), 2);
      checkReg("adcR2", 3'd2, 16'h0000);
      checkOutput("adcFlags", 32'(FlagsOut), 32'hC);

      // Src == Dest
      applyStimulus(mkInstr(OpAdd, 3'd1, srcField(3'd1)), 2);
      checkReg("addSelfR1", 3'd1, 16'hFFFE);
      checkOutput("addSelfFlags", 32'(FlagsOut), 32'hA);

      // InstrValid held high: only words seen while ready are taken
      words = '{mkInstr(OpLil, 3'd3, 8'h11), mkInstr(OpLil, 3'd4, 8'h22),
                mkInstr(OpLil, 3'd5, 8'h33), mkInstr(OpLil, 3'd6, 8'h44),
                mkInstr(OpLil, 3'd7, 8'h55), mkInstr(OpLil, 3'd3, 8'h66),
                mkInstr(OpLil, 3'd4, 8'h77), mkInstr(OpLil, 3'd5, 8'h88)};
      donePulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clock);
         if (Done) donePulses++;
         aluBus.InstrValid = 1'b1;
         aluBus.Instr      = words[i];
      end
      @(negedge Clock);
      if (Done) donePulses++;
      aluBus.InstrValid = 1'b0;
      aluBus.Instr      = '0;
      checkOutput("streamDonePulses", 32'(donePulses), 32'd2);
      checkReg("streamR3", 3'd3, 16'h0011);
      checkReg("streamR4", 3'd4, 16'h0000);
      checkReg("streamR5", 3'd5, 16'h0000);
      checkReg("streamR6", 3'd6, 16'h0000);
      checkReg("streamR7", 3'd7, 16'h0055);

      // Reset during EXECUTE of MOVE R3 <- R1
      @(negedge Clock);
      aluBus.InstrValid = 1'b1;
      aluBus.Instr      = mkInstr(OpMove, 3'd3, srcField(3'd1));
      @(posedge Clock);
      #1;
      aluBus.InstrValid = 1'b0;
      aluBus.Instr      = '0;
      @(posedge Clock);
      #1;
      checkOutput("abortOperandLatched", 32'(aluBus.AluInSrc), 32'h0000FFFE);
      nReset = 1'b0;
      #1;
      checkOutput("abortDone", 32'(Done), 32'd0);
      checkOutput("abortReady", 32'(aluBus.InstrReady), 32'd1);
      checkOutput("abortAluSrc", 32'(aluBus.AluInSrc), 32'd0);
      doneSeen = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge Clock);
         #1;
         if (Done) doneSeen++;
      end
      nReset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge Clock);
         #1;
         if (Done) doneSeen++;
      end
      checkOutput("abortNoDone", 32'(doneSeen), 32'd0);
      checkReg("abortR3", 3'd3, 16'h0000);
      checkReg("abortR1", 3'd1, 16'h0000);
      checkOutput("abortFlags", 32'(FlagsOut), 32'd0);

      // Ordinary divide
      applyStimulus(mkInstr(OpLil, 3'd5, 8'h09), 2);
      applyStimulus(mkInstr(OpLil, 3'd6, 8'h03), 2);
      applyStimulus(mkInstr(OpDiv, 3'd5, srcField(3'd6)), 2);
      checkReg("divR5", 3'd5, 16'h0003);

      // Zero flag set so later flag preservation is visible
      applyStimulus(mkInstr(OpAdc, 3'd7, srcField(3'd4)), 2);
      checkReg("adcZeroR7", 3'd7, 16'h0000);
      checkOutput("adcZeroFlags", 32'(FlagsOut), 32'h4);

      // Divide by zero
`ifdef DIV_ZERO_TRAP_EN
      checkOutput("divZeroErrBefore", 32'(DivZeroErr), 32'd0);
`endif
      applyStimulus(mkInstr(OpDiv, 3'd5, srcField(3'd4)), divZeroLatency);
      checkReg("divZeroR5", 3'd5, r5AfterDivZero);
      checkOutput("divZeroFlags", 32'(FlagsOut), 32'h4);
`ifdef DIV_ZERO_TRAP_EN
      checkOutput("divZeroErrSet", 32'(DivZeroErr), 32'd1);
`endif

      // Undefined opcode writes 0 and keeps flags
      applyStimulus(mkInstr(eOperation'(5'd31), 3'd6, srcField(3'd5)), 2);
      checkReg("undefR6", 3'd6, 16'h0000);
      checkOutput("undefFlags", 32'(FlagsOut), 32'h4);
`ifdef DIV_ZERO_TRAP_EN
      checkOutput("divZeroErrSticky", 32'(DivZeroErr), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
